// File: rtl/pulse_width_meter.sv
// Pulse width meter: arms on request, times one active pulse in prescaled ticks, reports via valid/ready.
// Define PULSE_WIDTH_METER_CONTINUOUS_EN to re-arm automatically after each accepted result.
module pulse_width_meter #(
  parameter int   MAX_COUNT    = 65535,
  parameter int   PRESCALE     = 1,
  parameter logic ACTIVE_LEVEL = 1'b1,
  localparam int  W            = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         signal_in,
  input  logic         arm,
  input  logic         abort,
  output logic [W-1:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         overflow,
  output logic         busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  T_MAX  = W'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, HOLD} state_t;

  state_t        state, state_d;
  logic          prev_sample;
  logic [PW-1:0] presc, presc_base, presc_nxt;
  logic [W-1:0]  tick, tick_base, tick_nxt;
  logic          sat, sat_base, sat_nxt;
  logic          active, lead, wrap, count_en;

  assign active = (signal_in == ACTIVE_LEVEL);
  assign lead   = active && (prev_sample != ACTIVE_LEVEL);
  assign busy   = (state != IDLE);

  // The edge sample counts from a cleared prescaler/counter, so base is zero outside MEASURE.
  always_comb begin
    presc_base = (state == MEASURE) ? presc : '0;
    tick_base  = (state == MEASURE) ? tick  : '0;
    sat_base   = (state == MEASURE) ? sat   : 1'b0;
    wrap       = (presc_base == P_LAST);
    presc_nxt  = wrap ? '0 : presc_base + 1'b1;
    tick_nxt   = (wrap && tick_base != T_MAX) ? tick_base + 1'b1 : tick_base;
    sat_nxt    = sat_base | (wrap && tick_base == T_MAX);
    count_en   = ((state == ARMED) && lead) || ((state == MEASURE) && active);
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (arm) state_d = ARMED;
      ARMED:   if (lead) state_d = MEASURE;
      MEASURE: if (!active) state_d = HOLD;
      HOLD: if (result_ready) begin
`ifdef PULSE_WIDTH_METER_CONTINUOUS_EN
        state_d = ARMED;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sample  <= ACTIVE_LEVEL;
      presc        <= '0;
      tick         <= '0;
      sat          <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      prev_sample <= signal_in;
      if (abort) begin
        result_valid <= 1'b0;
        overflow     <= 1'b0;
      end else begin
        if (count_en) begin
          presc <= presc_nxt;
          tick  <= tick_nxt;
          sat   <= sat_nxt;
        end
        if (state == MEASURE && !active) begin
          result       <= tick;
          overflow     <= sat;
          result_valid <= 1'b1;
        end
        if (state == HOLD && result_ready) result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: dut 0 uses defaults, dut 1 uses PRESCALE=4, MAX_COUNT=255.
module tb_pulse_width_meter;

  typedef struct {
    int res;
    bit ovf;
    int cyc;
  } exp_t;

  logic        clk = 0;
  logic        reset = 1;
  logic [1:0]  sig = '0, arm = '0, abrt = '0, rdy = '0;
  logic [15:0] res_a;
  logic [7:0]  res_b;
  logic        va, vb, ov_a, ov_b, busy_a, busy_b;

  int   total = 0, bad = 0, cyc = 0;
  exp_t q0[$], q1[$];
  exp_t cur[2];
  bit   pa = 0, pb = 0;

  pulse_width_meter dut_a (
    .clk(clk), .reset(reset), .signal_in(sig[0]), .arm(arm[0]), .abort(abrt[0]),
    .result(res_a), .result_valid(va), .result_ready(rdy[0]), .overflow(ov_a), .busy(busy_a)
  );

  pulse_width_meter #(.MAX_COUNT(255), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .signal_in(sig[1]), .arm(arm[1]), .abort(abrt[1]),
    .result(res_b), .result_valid(vb), .result_ready(rdy[1]), .overflow(ov_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int d, int res, bit ovf, int c);
    exp_t e;
    e.res = res; e.ovf = ovf; e.cyc = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(int d, bit v, bit vp, int res, bit ovf);
    exp_t e;
    if (v && !vp) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        total++; bad++;
        $display("FAIL unexpected_valid dut%0d got=1 exp=0 (t=%0t)", d, $time);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        cur[d] = e;
        chk($sformatf("rise_cycle_dut%0d", d), cyc, e.cyc);
        chk($sformatf("result_dut%0d", d), res, e.res);
        chk($sformatf("overflow_dut%0d", d), int'(ovf), int'(e.ovf));
      end
    end else if (v) begin
      chk($sformatf("hold_result_dut%0d", d), res, cur[d].res);
      chk($sformatf("hold_overflow_dut%0d", d), int'(ovf), int'(cur[d].ovf));
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, va, pa, int'(res_a), ov_a);
    pa = va;
    mon(1, vb, pb, int'(res_b), ov_b);
    pb = vb;
  end

  // Low for lo cycles, high for hi cycles, then the first low sample; result_valid rises on that edge.
  task automatic pulse(int d, int lo, int hi, bit expect_out, int res, bit ovf);
    sig[d] = 1'b0;
    step(lo);
    sig[d] = 1'b1;
    step(hi);
    sig[d] = 1'b0;
    if (expect_out) push(d, res, ovf, cyc + 1);
    step(1);
  endtask

  task automatic do_arm(int d);
    arm[d] = 1'b1;
    step(1);
    arm[d] = 1'b0;
  endtask

  task automatic accept(int d);
    rdy[d] = 1'b1;
    step(1);
    rdy[d] = 1'b0;
    chk($sformatf("valid_after_accept_dut%0d", d), d == 0 ? int'(va) : int'(vb), 0);
  endtask

  initial begin
    #2;
    chk("reset_result_a", int'(res_a), 0);
    chk("reset_valid_a", int'(va), 0);
    chk("reset_overflow_a", int'(ov_a), 0);
    chk("reset_busy_a", int'(busy_a), 0);
    chk("reset_busy_b", int'(busy_b), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic PRESCALE=1 measurement
    sig[0] = 1'b0;
    do_arm(0);
    chk("busy_armed_a", int'(busy_a), 1);
    pulse(0, 3, 10, 1, 10, 0);
    accept(0);
`ifdef PULSE_WIDTH_METER_CONTINUOUS_EN
    chk("busy_after_accept_a", int'(busy_a), 1);
`else
    chk("busy_after_accept_a", int'(busy_a), 0);
`endif

    // Prescaled, truncation and saturation
    do_arm(1); pulse(1, 2, 4, 1, 1, 0);     accept(1);
    do_arm(1); pulse(1, 2, 7, 1, 1, 0);     accept(1);
    do_arm(1); pulse(1, 2, 3, 1, 0, 0);     accept(1);
    do_arm(1); pulse(1, 2, 8, 1, 2, 0);     accept(1);
    do_arm(1); pulse(1, 2, 1023, 1, 255, 0); accept(1);
    do_arm(1); pulse(1, 2, 1024, 1, 255, 1); accept(1);

    // Already active when armed: the in-progress pulse is skipped
    sig[0] = 1'b1;
    step(2);
    do_arm(0);
    step(19);
    pulse(0, 5, 6, 1, 6, 0);
    accept(0);

    // Backpressure: pulses during HOLD are ignored and outputs stay put
    do_arm(0);
    pulse(0, 2, 7, 1, 7, 0);
    for (int i = 0; i < 50; i++) begin
      sig[0] = ((i / 3) % 2) == 1;
      step(1);
    end
    chk("valid_held_a", int'(va), 1);
    sig[0] = 1'b0;
    accept(0);

    // Abort mid-measure
`ifndef PULSE_WIDTH_METER_CONTINUOUS_EN
    do_arm(0);
`endif
    sig[0] = 1'b0; step(2);
    sig[0] = 1'b1; step(5);
    abrt[0] = 1'b1; step(1); abrt[0] = 1'b0;
    chk("busy_after_abort_a", int'(busy_a), 0);
    step(4);
    sig[0] = 1'b0; step(3);
    chk("valid_after_abort_a", int'(va), 0);
    chk("result_kept_after_abort_a", int'(res_a), 7);

    // Abort with arm in IDLE stays IDLE
    abrt[0] = 1'b1; arm[0] = 1'b1; step(1);
    abrt[0] = 1'b0; arm[0] = 1'b0;
    chk("abort_arm_idle_busy_a", int'(busy_a), 0);

    // Async reset mid-measure clears everything without a clock edge
    do_arm(1);
    sig[1] = 1'b0; step(2);
    sig[1] = 1'b1; step(10);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_busy_b", int'(busy_b), 0);
    chk("async_reset_result_b", int'(res_b), 0);
    chk("async_reset_result_a", int'(res_a), 0);
    chk("async_reset_valid_b", int'(vb), 0);
    chk("async_reset_overflow_b", int'(ov_b), 0);
    sig[1] = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);

`ifdef PULSE_WIDTH_METER_CONTINUOUS_EN
    do_arm(0);
    pulse(0, 2, 8, 1, 8, 0);  accept(0); chk("cont_busy_1", int'(busy_a), 1);
    pulse(0, 2, 12, 1, 12, 0); accept(0); chk("cont_busy_2", int'(busy_a), 1);
    pulse(0, 2, 3, 1, 3, 0);  accept(0); chk("cont_busy_3", int'(busy_a), 1);
`endif

    step(3);
    chk("pending_expect_a", q0.size(), 0);
    chk("pending_expect_b", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
Controller that sequences a binary tick counter to measure the width of one active pulse on a synchronised mechanism signal, e.g. a motor phase or strobe line.
- Arms on request, waits for a fresh leading edge, counts prescaled clock ticks while the signal stays active, then presents the saturated result on a valid/ready handshake.
- Sits between the input synchroniser/edge logic and the measurement capture/UART reporting path.

Parameters:
MAX_COUNT, 65535, largest reportable width in ticks; W = $clog2(MAX_COUNT+1)
PRESCALE, 1, clock cycles per tick; must be >= 1
ACTIVE_LEVEL, 1'b1, level of signal_in that counts as the pulse

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
signal_in  input  1  already-synchronised signal under measurement
arm  input  1  single-cycle request to start one measurement; honoured only in IDLE
abort  input  1  return to IDLE from any state, discarding any measurement
result  output  W  measured width in ticks, stable while result_valid
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
overflow  output  1  result saturated; qualified by result_valid
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous and active-high: state=IDLE, result=0, result_valid=0, overflow=0, busy=0, prescaler=0, tick count=0, prev_sample=ACTIVE_LEVEL.
- prev_sample <= signal_in every cycle in every state.
- Leading edge = (signal_in==ACTIVE_LEVEL) && (prev_sample!=ACTIVE_LEVEL).
- Because prev_sample resets to ACTIVE_LEVEL, no edge fires on the first cycle after reset.
- FSM states: IDLE, ARMED, MEASURE, HOLD.
- IDLE: arm=1 -> ARMED next cycle. arm in any other state is ignored.
- ARMED: waits for a leading edge; the edge cycle is the first active sample -> MEASURE.
- ARMED: if the signal is already active when armed, it must go inactive and return active before measurement starts.
- MEASURE: runs while signal_in==ACTIVE_LEVEL. The first cycle with signal_in inactive -> HOLD.
- MEASURE exit: on that same edge result <= saturated tick count and result_valid <= 1, so result_valid rises the cycle after the first inactive sample.
- Width rule: N = number of consecutive active samples, including the edge sample.
  - result = min(floor(N/PRESCALE), MAX_COUNT).
  - overflow = (floor(N/PRESCALE) > MAX_COUNT).
  - Partial prescale periods are truncated.
- Tick counter saturates at MAX_COUNT and never wraps.
- Prescaler wraps PRESCALE-1 -> 0 and increments the tick counter on wrap.
- Both the prescaler and the tick counter are cleared on entry to MEASURE.
- HOLD:
  - result and overflow are held constant and result_valid stays 1 until result_valid && result_ready.
  - On that handshake cycle: result_valid <= 0 -> IDLE.
  - Edges during HOLD are not measured.
- abort (highest priority after reset): any state -> IDLE next cycle.
  - result_valid <= 0, overflow <= 0; result keeps its last value.
  - abort together with arm in IDLE: stays IDLE.
- abort and result_ready together in HOLD: abort wins; same outcome, no extra effect.
- Reset mid-operation: immediate return to reset values; any measurement in progress is lost.
- result_ready outside HOLD is ignored.
- busy is combinational from state.

Optional Feature:
PULSE_WIDTH_METER_CONTINUOUS_EN
- Defined: after the HOLD handshake, go to ARMED instead of IDLE, so repeated pulses are measured without further arm; arm is still needed to leave IDLE after reset/abort.
- Undefined: one-shot behaviour as above, HOLD -> IDLE.
- abort and reset behave identically in both builds.

Test Plan:
- Defaults, PRESCALE=1: arm, then signal_in low 3 cycles, high 10 cycles, low -> result=10, overflow=0, result_valid 1 cycle after first low sample; result_ready=1 -> IDLE, busy=0.
- PRESCALE=4, MAX_COUNT=255: 4-cycle pulse -> result=1; 7-cycle pulse -> result=1; 1024-cycle pulse -> result=255, overflow=1 (saturated, no wrap).
- Signal already high at arm for 20 cycles, then low 5, high 6 -> result=6; the initial 20-cycle pulse is not counted.
- Backpressure: result_ready held 0 for 50 cycles in HOLD while further pulses occur -> result, overflow and result_valid unchanged; accept on cycle 51 -> result_valid=0 next cycle.
- abort mid-MEASURE after 5 active cycles -> IDLE next cycle, result_valid never asserts, busy=0; async reset asserted mid-MEASURE -> all outputs 0 immediately.
- PULSE_WIDTH_METER_CONTINUOUS_EN defined: one arm, three pulses of 8/12/3 cycles, each result accepted -> results 8, 12, 3; busy stays 1 throughout.
